// File: rtl/emern_vga_timing.sv
// VGA 640x480@60 raster timing: column/row counters with registered sync and blanking flags.
// Optional frame_start pulse output when VGA_FRAME_START_EN is defined.
module emern_vga_timing #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        h_sync,
   output logic        v_sync,
   output logic [9:0]  row_counter,
   output logic [9:0]  col_counter,
   output logic        screen_inactive
`ifdef VGA_FRAME_START_EN
   ,output logic       frame_start
`endif
);

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [CNT_W-1:0] col_next;
   logic [CNT_W-1:0] row_next;
   logic             h_sync_next;
   logic             v_sync_next;
   logic             inactive_next;

   // Counter advance; any out-of-range value folds back to zero on the next edge.
   always_comb begin
      col_next = col_counter + CNT_W'(1);
      row_next = row_counter;
      if (col_counter >= H_LAST) begin
         col_next = '0;
         if (row_counter >= V_LAST) begin
            row_next = '0;
         end else begin
            row_next = row_counter + CNT_W'(1);
         end
      end else if (row_counter > V_LAST) begin
         row_next = '0;
      end
   end

   // Flags are decoded from next-state counters so they land on the same edge as the counters.
   always_comb begin
      h_sync_next   = ~((col_next >= H_SYNC_FIRST) && (col_next <= H_SYNC_LAST));
      v_sync_next   = ~((row_next >= V_SYNC_FIRST) && (row_next <= V_SYNC_LAST));
      inactive_next = (col_next >= H_VIS_END) || (row_next >= V_VIS_END);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_counter     <= '0;
         row_counter     <= '0;
         h_sync          <= 1'b1;
         v_sync          <= 1'b1;
         screen_inactive <= 1'b0;
      end else begin
         col_counter     <= col_next;
         row_counter     <= row_next;
         h_sync          <= h_sync_next;
         v_sync          <= v_sync_next;
         screen_inactive <= inactive_next;
      end
   end

`ifdef VGA_FRAME_START_EN
   logic frame_start_next;

   // Only a wrap into (0,0) raises the pulse; reset itself does not.
   always_comb begin
      frame_start_next = (col_next == '0) && (row_next == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_start_next;
      end
   end
`endif

endmodule

// File: tb/tb_emern_vga_timing.sv
// Directed bench for emern_vga_timing: full-size instance for horizontal timing,
// shrunken-parameter instance for vertical timing and frame wrap.
module tb_emern_vga_timing;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hs_a, vs_a, si_a;
   logic [9:0] row_a, col_a;
   logic       hs_b, vs_b, si_b;
   logic [9:0] row_b, col_b;
`ifdef VGA_FRAME_START_EN
   logic       fs_a, fs_b;
`endif

   int checks   = 0;
   int failures = 0;
   int t        = 0;

   // Small geometry: 16 clocks per line, 12 lines per frame, 192 clocks per frame.
   localparam int SH_TOT = 16;
   localparam int SV_TOT = 12;

   always #5 clk = ~clk;

   emern_vga_timing u_a (
      .clk             (clk),
      .rst_n           (rst_n),
      .h_sync          (hs_a),
      .v_sync          (vs_a),
      .row_counter     (row_a),
      .col_counter     (col_a),
      .screen_inactive (si_a)
`ifdef VGA_FRAME_START_EN
      ,.frame_start    (fs_a)
`endif
   );

   emern_vga_timing #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
      .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
   ) u_b (
      .clk             (clk),
      .rst_n           (rst_n),
      .h_sync          (hs_b),
      .v_sync          (vs_b),
      .row_counter     (row_b),
      .col_counter     (col_b),
      .screen_inactive (si_b)
`ifdef VGA_FRAME_START_EN
      ,.frame_start    (fs_b)
`endif
   );

   typedef struct {
      int   cyc;
      int   col;
      int   row;
      logic h;
      logic v;
      logic si;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%0d expected=%0d", name, t, act, exp);
      end
   endtask

   // Arithmetic reference for the small instance, valid for the first three frames.
   task automatic per_cycle();
      int ec, er;
      if (t < 3 * SH_TOT * SV_TOT) begin
         ec = t % SH_TOT;
         er = (t / SH_TOT) % SV_TOT;
         chk("b_col", 32'(col_b), 32'(ec));
         chk("b_row", 32'(row_b), 32'(er));
         chk("b_hsync", 32'(hs_b), 32'(!(ec >= 10 && ec <= 12)));
         chk("b_vsync", 32'(vs_b), 32'(!(er >= 8 && er <= 9)));
         chk("b_inactive", 32'(si_b), 32'(ec >= 8 || er >= 6));
`ifdef VGA_FRAME_START_EN
         chk("a_frame_start", 32'(fs_a), 32'(0));
         chk("b_frame_start", 32'(fs_b), 32'(t > 0 && (t % (SH_TOT * SV_TOT)) == 0));
`endif
      end
   endtask

   task automatic step_to(input int target);
      while (t < target) begin
         @(negedge clk);
         t++;
         per_cycle();
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_col_a"}, 32'(col_a), 32'(0));
      chk({tag, "_row_a"}, 32'(row_a), 32'(0));
      chk({tag, "_hs_a"},  32'(hs_a),  32'(1));
      chk({tag, "_vs_a"},  32'(vs_a),  32'(1));
      chk({tag, "_si_a"},  32'(si_a),  32'(0));
      chk({tag, "_col_b"}, 32'(col_b), 32'(0));
      chk({tag, "_row_b"}, 32'(row_b), 32'(0));
      chk({tag, "_hs_b"},  32'(hs_b),  32'(1));
      chk({tag, "_vs_b"},  32'(vs_b),  32'(1));
      chk({tag, "_si_b"},  32'(si_b),  32'(0));
`ifdef VGA_FRAME_START_EN
      chk({tag, "_fs_a"},  32'(fs_a),  32'(0));
      chk({tag, "_fs_b"},  32'(fs_b),  32'(0));
`endif
   endtask

   initial begin
      int   low_cnt, first_low_col, fall_n, fs_cnt, v_low;
      int   falls[2];
      logic prev_v;

      vecs[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{640,  640, 0, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{655,  655, 0, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{751,  751, 0, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{752,  752, 0, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{799,  799, 0, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{801,  1,   1, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1599, 799, 1, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{1600, 0,   2, 1'b1, 1'b1, 1'b0};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("por");

      rst_n = 1'b1;
      t = 0;
      per_cycle();

      foreach (vecs[i]) begin
         step_to(vecs[i].cyc);
         chk("a_col",      32'(col_a), 32'(vecs[i].col));
         chk("a_row",      32'(row_a), 32'(vecs[i].row));
         chk("a_hsync",    32'(hs_a),  32'(vecs[i].h));
         chk("a_vsync",    32'(vs_a),  32'(vecs[i].v));
         chk("a_inactive", 32'(si_a),  32'(vecs[i].si));
      end

      // Horizontal sync pulse width and position over line 2.
      low_cnt = 0;
      first_low_col = -1;
      for (int k = 0; k < 800; k++) begin
         step_to(t + 1);
         if (hs_a == 1'b0) begin
            if (low_cnt == 0) first_low_col = int'(col_a);
            low_cnt++;
         end
      end
      chk("a_hsync_width", 32'(low_cnt), 32'(96));
      chk("a_hsync_start", 32'(first_low_col), 32'(656));
      chk("a_row_after_line2", 32'(row_a), 32'(3));

      // Small instance: v_sync width, frame period, frame_start count over 3 frames.
      fall_n = 0;
      falls[0] = -1;
      falls[1] = -1;
      fs_cnt = 0;
      v_low = 0;
      prev_v = vs_b;
      for (int k = 0; k < 3 * SH_TOT * SV_TOT; k++) begin
         step_to(t + 1);
         if (prev_v && !vs_b && fall_n < 2) begin
            falls[fall_n] = t;
            fall_n++;
         end
         if (!vs_b && fall_n == 1) v_low++;
         prev_v = vs_b;
`ifdef VGA_FRAME_START_EN
         if (fs_b) fs_cnt++;
`endif
      end
      chk("b_vsync_period", 32'(falls[1] - falls[0]), 32'(SH_TOT * SV_TOT));
      chk("b_vsync_width", 32'(v_low), 32'(2 * SH_TOT));
`ifdef VGA_FRAME_START_EN
      chk("b_frame_start_count", 32'(fs_cnt), 32'(3));
`endif

      // Asynchronous reset in the middle of a line and a frame.
      step_to(3100);
      chk("a_hsync_pre_reset", 32'(hs_a), 32'(0));
      chk("a_col_pre_reset", 32'(col_a), 32'(700));
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      repeat (3) @(negedge clk);
      chk_reset_vals("held");
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_col_a", 32'(col_a), 32'(1));
      chk("rel_row_a", 32'(row_a), 32'(0));
      chk("rel_col_b", 32'(col_b), 32'(1));
      chk("rel_si_b",  32'(si_b),  32'(0));
`ifdef VGA_FRAME_START_EN
      chk("rel_fs_a",  32'(fs_a),  32'(0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/emern_vga_timing.md
Name: emern_vga_timing

Overview:
- VGA 640x480@60 Hz raster timing generator, driven by one 25.175/25 MHz pixel clock.
- Produces horizontal and vertical sync, the current pixel column/row counters, and a blanking flag.
- Sits between the clock/reset source and the pixel-colour logic. That logic uses col_counter/row_counter to address pixels and screen_inactive to force black.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525

Ports:
- clk  input  1  pixel clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- h_sync  output  1  horizontal sync, active low
- v_sync  output  1  vertical sync, active low
- row_counter  output  10  current line, 0..V_TOTAL-1
- col_counter  output  10  current pixel within line, 0..H_TOTAL-1
- screen_inactive  output  1  high when current (col,row) is outside the visible area

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset, asserted at any time including mid-frame:
  - col_counter=0, row_counter=0
  - h_sync=1, v_sync=1, screen_inactive=0
  - Outputs take these values immediately, without waiting for a clock edge.
- First rising edge after rst_n deasserts: col_counter becomes 1.
- Column counter:
  - Increments by 1 every clock.
  - At H_TOTAL-1 (799) it wraps to 0 on the next clock.
- Row counter:
  - Increments by 1 only on the clock where col_counter wraps 799->0.
  - When row_counter=V_TOTAL-1 (524) and col_counter=799, both wrap to 0 on the same clock (frame boundary).
- Outputs are a pure decode of the current counter values, with zero latency. In the cycle col_counter=N, all flags reflect column N.
- Decode must be glitch-free: either register the flags alongside the counters using next-state values, or decode from registers only, so the outputs stay aligned with the counters.
- h_sync=0 iff H_VISIBLE+H_FRONT <= col_counter <= H_VISIBLE+H_FRONT+H_SYNC-1, i.e. col 656..751. Otherwise 1.
- v_sync=0 iff V_VISIBLE+V_FRONT <= row_counter <= V_VISIBLE+V_FRONT+V_SYNC-1, i.e. rows 490..491, for all columns of those rows. Otherwise 1.
- screen_inactive=1 iff col_counter >= H_VISIBLE OR row_counter >= V_VISIBLE.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Any out-of-range value, e.g. after a parameter change, wraps to 0 on the next clock.
- Counter widths are fixed at 10 bits. Parameters must satisfy H_TOTAL, V_TOTAL <= 1024.
- Frame period: 800*525 = 420000 clocks.

Optional Feature:
- Macro: VGA_FRAME_START_EN.
- When defined:
  - Adds output port frame_start (1 bit).
  - frame_start is high for exactly one clock, the cycle where col_counter=0 and row_counter=0.
  - frame_start resets to 0 while rst_n is low.
  - The first pulse occurs in the cycle at (0,0) following reset release; because the counter has already moved to 1 on that first edge, this is the cycle after the first wrap, 420000 clocks after release.
- When not defined: the port is absent and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-frame -> immediately col=0, row=0, h_sync=1, v_sync=1, screen_inactive=0. Release, one clock -> col=1.
- Horizontal timing: run one line from reset.
  - h_sync=1 at col 655, 0 at col 656 and col 751, 1 at col 752.
  - Pulse length is exactly 96 clocks.
  - col 799 -> 0 with row 0 -> 1.
- Blanking: screen_inactive=0 at (639,0), 1 at (640,0), 0 at (0,479), 1 at (0,480) and at (0,524).
- Vertical timing: v_sync=1 on row 489, 0 throughout rows 490 and 491, 1 from row 492. Pulse lasts exactly 2*800=1600 clocks.
- Frame wrap: at (799,524) the next clock gives (0,0). Frame period measured between successive v_sync falling edges is 420000 clocks.
- With VGA_FRAME_START_EN: frame_start pulses once per 420000 clocks, width 1, coincident with (0,0). No pulse while rst_n=0.
